// File: rtl/caf_freq_step_gen_if.sv
// caf_freq_step_gen_if: beat interface carrying one frequency step per CAF slice.
// Macro CAF_FSG_TLAST_EN adds tlast (high on the final slice's beat).
//   tvalid          : beat valid (master -> slave)
//   tready          : beat accepted (slave -> master)
//   freq_step       : step magnitude, phase_bits wide
//   neg_shift       : step is negative (slice below center)
//   freq_step_index : slice index of the beat
//   tlast           : last slice (only with CAF_FSG_TLAST_EN)
interface caf_freq_step_gen_if #(
  parameter int unsigned phase_bits        = 10,
  parameter int unsigned foas_counter_bits = 3
);
  logic                         tvalid;
  logic                         tready;
  logic [phase_bits-1:0]        freq_step;
  logic                         neg_shift;
  logic [foas_counter_bits-1:0] freq_step_index;
`ifdef CAF_FSG_TLAST_EN
  logic                         tlast;
`endif

  modport master (
    output tvalid,
    input  tready,
    output freq_step,
    output neg_shift,
`ifdef CAF_FSG_TLAST_EN
    output tlast,
`endif
    output freq_step_index
  );

  modport slave (
    input  tvalid,
    output tready,
    input  freq_step,
    input  neg_shift,
`ifdef CAF_FSG_TLAST_EN
    input  tlast,
`endif
    input  freq_step_index
  );
endinterface

// File: rtl/caf_freq_step_gen.sv
// caf_freq_step_gen: on a start pulse, emits foas frequency steps
// (k - center) * spacing, one beat per slice in slice order, built by
// accumulation (no multiplier). All arithmetic wraps mod 2^phase_bits.
// Optional macro CAF_FSG_TLAST_EN adds m_axis.tlast.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : begin a load sequence (ignored unless idle)
//   spacing    : frequency spacing, latched on accepted start
//   m_axis     : beat master (tvalid/tready/freq_step/neg_shift/freq_step_index)
//   busy       : accepted start until last beat accepted
//   done       : one-cycle pulse after last beat accepted
module caf_freq_step_gen #(
  parameter int unsigned phase_bits        = 10,
  parameter int unsigned foas              = 3,
  parameter int unsigned foas_counter_bits = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [phase_bits-1:0] spacing,
  caf_freq_step_gen_if.master   m_axis,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CENTER = foas / 2;
  localparam logic [foas_counter_bits-1:0] C_CENTER   = foas_counter_bits'(CENTER);
  localparam logic [foas_counter_bits-1:0] C_LAST     = foas_counter_bits'(foas - 1);
  localparam logic [foas_counter_bits-1:0] C_PRE_LAST =
    foas_counter_bits'((CENTER > 0) ? CENTER - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_SEND, S_DONE} state_t;

  state_t                       r_state;
  logic [phase_bits-1:0]        r_spacing;
  logic [phase_bits-1:0]        r_mag;
  logic [foas_counter_bits-1:0] r_k;
  logic [foas_counter_bits-1:0] r_pre_cnt;
  logic                         r_valid;
  logic                         r_neg;
  logic                         r_busy;
  logic                         r_done;
`ifdef CAF_FSG_TLAST_EN
  logic                         r_tlast;
`endif

  logic [foas_counter_bits-1:0] w_k_next;
  logic [phase_bits-1:0]        w_mag_next;

  // Magnitude walks down toward zero below center, then back up.
  assign w_k_next   = r_k + foas_counter_bits'(1);
  assign w_mag_next = (r_k < C_CENTER) ? (r_mag - r_spacing) : (r_mag + r_spacing);

  // Sequencer: preload |0-center|*spacing, then stream one beat per slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_spacing <= '0;
      r_mag     <= '0;
      r_k       <= '0;
      r_pre_cnt <= '0;
      r_valid   <= 1'b0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef CAF_FSG_TLAST_EN
      r_tlast   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_spacing <= spacing;
            r_mag     <= '0;
            r_k       <= '0;
            r_pre_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= (CENTER > 0) ? S_PRELOAD : S_SEND;
          end
        end
        S_PRELOAD: begin
          r_mag     <= r_mag + r_spacing;
          r_pre_cnt <= r_pre_cnt + foas_counter_bits'(1);
          if (r_pre_cnt == C_PRE_LAST) r_state <= S_SEND;
        end
        S_SEND: begin
          if (!r_valid) begin
            // First beat is presented one cycle after entering SEND.
            r_valid <= 1'b1;
            r_neg   <= (r_k < C_CENTER);
`ifdef CAF_FSG_TLAST_EN
            r_tlast <= (r_k == C_LAST);
`endif
          end else if (m_axis.tready) begin
            if (r_k == C_LAST) begin
              r_valid <= 1'b0;
              r_neg   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
`ifdef CAF_FSG_TLAST_EN
              r_tlast <= 1'b0;
`endif
            end else begin
              r_mag   <= w_mag_next;
              r_k     <= w_k_next;
              r_neg   <= (w_k_next < C_CENTER);
`ifdef CAF_FSG_TLAST_EN
              r_tlast <= (w_k_next == C_LAST);
`endif
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis.tvalid          = r_valid;
  assign m_axis.freq_step       = r_mag;
  assign m_axis.neg_shift       = r_neg;
  assign m_axis.freq_step_index = r_k;
`ifdef CAF_FSG_TLAST_EN
  assign m_axis.tlast           = r_tlast;
`endif
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_caf_freq_step_gen.sv
// tb_caf_freq_step_gen: scoreboard bench for two generator instances
// (foas=3 and foas=5, phase_bits=10). Expected beats are queued by the
// stimulus; per-instance monitors compare each presented beat and the done pulse.
module tb_caf_freq_step_gen;

  typedef struct {
    logic [9:0] step;
    logic       neg;
    logic [2:0] idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start3 = 1'b0, start5 = 1'b0;
  logic [9:0] spacing3 = '0, spacing5 = '0;
  logic busy3, done3, busy5, done5;

  int checks = 0;
  int errors = 0;

  beat_t q3[$];
  beat_t q5[$];
  logic  exp_done3 = 1'b0, exp_done5 = 1'b0;

  caf_freq_step_gen_if #(.phase_bits(10), .foas_counter_bits(2)) if3 ();
  caf_freq_step_gen_if #(.phase_bits(10), .foas_counter_bits(3)) if5 ();

  caf_freq_step_gen #(.phase_bits(10), .foas(3), .foas_counter_bits(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .spacing(spacing3),
    .m_axis(if3), .busy(busy3), .done(done3)
  );

  caf_freq_step_gen #(.phase_bits(10), .foas(5), .foas_counter_bits(3)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .spacing(spacing5),
    .m_axis(if5), .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push3(input int step, input int neg, input int idx);
    beat_t b;
    b.step = 10'(step); b.neg = 1'(neg); b.idx = 3'(idx);
    q3.push_back(b);
  endtask

  task automatic push5(input int step, input int neg, input int idx);
    beat_t b;
    b.step = 10'(step); b.neg = 1'(neg); b.idx = 3'(idx);
    q5.push_back(b);
  endtask

  // Monitor for the foas=3 instance: peek while stalled, pop on acceptance.
  always @(negedge clk) begin
    logic nd;
    if (!rst_n) begin
      exp_done3 = 1'b0;
    end else begin
      nd = 1'b0;
      chk("done3", int'(done3), int'(exp_done3));
      if (exp_done3) chk("busy3_at_done", int'(busy3), 0);
      if (if3.tvalid) begin
        chk("busy3_in_send", int'(busy3), 1);
        if (q3.size() == 0) begin
          chk("unexpected_beat3", 1, 0);
        end else begin
          chk("step3", int'(if3.freq_step), int'(q3[0].step));
          chk("neg3", int'(if3.neg_shift), int'(q3[0].neg));
          chk("idx3", int'(if3.freq_step_index), int'(q3[0].idx));
`ifdef CAF_FSG_TLAST_EN
          chk("tlast3", int'(if3.tlast), int'(q3[0].idx == 3'd2));
`endif
          if (if3.tready) begin
            if (q3[0].idx == 3'd2) nd = 1'b1;
            void'(q3.pop_front());
          end
        end
      end
      exp_done3 = nd;
    end
  end

  // Monitor for the foas=5 instance.
  always @(negedge clk) begin
    logic nd;
    if (!rst_n) begin
      exp_done5 = 1'b0;
    end else begin
      nd = 1'b0;
      chk("done5", int'(done5), int'(exp_done5));
      if (exp_done5) chk("busy5_at_done", int'(busy5), 0);
      if (if5.tvalid) begin
        chk("busy5_in_send", int'(busy5), 1);
        if (q5.size() == 0) begin
          chk("unexpected_beat5", 1, 0);
        end else begin
          chk("step5", int'(if5.freq_step), int'(q5[0].step));
          chk("neg5", int'(if5.neg_shift), int'(q5[0].neg));
          chk("idx5", int'(if5.freq_step_index), int'(q5[0].idx));
`ifdef CAF_FSG_TLAST_EN
          chk("tlast5", int'(if5.tlast), int'(q5[0].idx == 3'd4));
`endif
          if (if5.tready) begin
            if (q5[0].idx == 3'd4) nd = 1'b1;
            void'(q5.pop_front());
          end
        end
      end
      exp_done5 = nd;
    end
  end

  // Pulse start for one cycle; returns just after the sampling edge.
  task automatic pulse_start(input int which, input logic [9:0] sp);
    @(posedge clk); #1;
    if (which == 3) begin start3 = 1'b1; spacing3 = sp; end
    else            begin start5 = 1'b1; spacing5 = sp; end
    @(posedge clk); #1;
    start3 = 1'b0; start5 = 1'b0;
  endtask

  // Cycles from the sampling edge until valid is seen.
  task automatic check_latency(input int which, input int exp);
    int cnt = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      seen = (which == 3) ? if3.tvalid : if5.tvalid;
    end
    chk((which == 3) ? "latency3" : "latency5", seen ? cnt : -1, exp);
  endtask

  task automatic wait_done(input int which);
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 3) ? done3 : done5;
    end
    chk((which == 3) ? "done3_timeout" : "done5_timeout", int'(seen), 1);
    chk((which == 3) ? "q3_drained" : "q5_drained",
        (which == 3) ? q3.size() : q5.size(), 0);
  endtask

  initial begin
    if3.tready = 1'b1;
    if5.tready = 1'b1;
    #12;
    // Reset values
    chk("rst_valid3", int'(if3.tvalid), 0);
    chk("rst_busy3", int'(busy3), 0);
    chk("rst_done3", int'(done3), 0);
    chk("rst_step3", int'(if3.freq_step), 0);
    chk("rst_idx3", int'(if3.freq_step_index), 0);
    chk("rst_neg3", int'(if3.neg_shift), 0);
    chk("rst_valid5", int'(if5.tvalid), 0);
    chk("rst_busy5", int'(busy5), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: foas=3 spacing=10, spacing changed after latch must not matter
    push3(10, 1, 0); push3(0, 0, 1); push3(10, 0, 2);
    pulse_start(3, 10'd10);
    spacing3 = 10'd55;
    chk("busy3_after_start", int'(busy3), 1);
    check_latency(3, 2);
    wait_done(3);

    // 2: foas=5 spacing=7
    push5(14, 1, 0); push5(7, 1, 1); push5(0, 0, 2); push5(7, 0, 3); push5(14, 0, 4);
    pulse_start(5, 10'd7);
    check_latency(5, 3);
    wait_done(5);

    // 3: backpressure on idx1 for three cycles
    if3.tready = 1'b0;
    push3(10, 1, 0); push3(0, 0, 1); push3(10, 0, 2);
    pulse_start(3, 10'd10);
    check_latency(3, 2);
    @(posedge clk); #1 if3.tready = 1'b1;
    @(posedge clk); #1 if3.tready = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 if3.tready = 1'b1;
    wait_done(3);

    // 4: modular wrap, foas=5 spacing=600
    push5(176, 1, 0); push5(600, 1, 1); push5(0, 0, 2); push5(600, 0, 3); push5(176, 0, 4);
    pulse_start(5, 10'd600);
    check_latency(5, 3);
    wait_done(5);

    // 5: start during SEND is ignored
    push3(10, 1, 0); push3(0, 0, 1); push3(10, 0, 2);
    pulse_start(3, 10'd10);
    check_latency(3, 2);
    @(posedge clk); #1 start3 = 1'b1; spacing3 = 10'd99;
    @(posedge clk); #1 start3 = 1'b0;
    wait_done(3);
    repeat (8) @(negedge clk);
    chk("no_restart3", int'(if3.tvalid), 0);
    chk("idle_busy3", int'(busy3), 0);

    // 6: reset while idx1 is presented, then restart with spacing=4
    if3.tready = 1'b0;
    push3(10, 1, 0); push3(0, 0, 1); push3(10, 0, 2);
    pulse_start(3, 10'd10);
    check_latency(3, 2);
    @(posedge clk); #1 if3.tready = 1'b1;
    @(posedge clk); #1 if3.tready = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_valid3", int'(if3.tvalid), 0);
    chk("arst_busy3", int'(busy3), 0);
    chk("arst_done3", int'(done3), 0);
    chk("arst_idx3", int'(if3.freq_step_index), 0);
    q3.delete();
    @(posedge clk); #1 rst_n = 1'b1; if3.tready = 1'b1;
    push3(4, 1, 0); push3(0, 0, 1); push3(4, 0, 2);
    pulse_start(3, 10'd4);
    check_latency(3, 2);
    wait_done(3);

    repeat (4) @(negedge clk);
    chk("final_q3", q3.size(), 0);
    chk("final_q5", q5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
